// File: rtl/if_id_queue.sv
// if_id_queue: fetch-to-decode instruction queue.
// Circular FIFO of {pc, instr} pairs. The oldest entry is presented to decode.
// Fetch is frozen while the queue is full. A taken branch (flush) empties it.
// Optional build macro IF_ID_QUEUE_BYPASS_EN: when the queue is empty, an
// offered fetch word goes straight to id_* in the same cycle, with zero latency.
module if_id_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     if_valid,
  input  logic [31:0]              if_pc,
  input  logic [31:0]              if_instr,
  output logic                     if_freeze,
  input  logic                     id_stall,
  output logic                     id_valid,
  output logic [31:0]              id_pc,
  output logic [31:0]              id_instr,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [CW-1:0] cnt;
  logic          empty;
  logic          full;
  logic          enq;
  logic          deq;

  assign empty     = (cnt == '0);
  assign full      = (cnt == CW'(DEPTH));
  // Freeze depends only on the registered occupancy, so decode stalls never
  // ripple combinationally back into fetch.
  assign if_freeze = full;
  assign count     = cnt;

  // Handshake decode and head presentation; an empty queue shows an all-zero bubble.
  always_comb begin
    enq      = if_valid & ~full & ~flush;
    deq      = ~empty & ~id_stall & ~flush;
    id_valid = ~empty;
    id_pc    = empty ? 32'h0 : pc_mem[rp];
    id_instr = empty ? 32'h0 : instr_mem[rp];
`ifdef IF_ID_QUEUE_BYPASS_EN
    if (empty && if_valid && !flush) begin
      id_valid = 1'b1;
      id_pc    = if_pc;
      id_instr = if_instr;
      // Consumed directly by decode, so nothing is written.
      if (!id_stall) enq = 1'b0;
    end
`endif
  end

  // Pointer and occupancy update; flush wins over enqueue and dequeue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else if (flush) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (enq) wp <= wp + 1'b1;
      if (deq) rp <= rp + 1'b1;
      case ({enq, deq})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Entry storage; contents are never visible while empty, so no reset.
  always_ff @(posedge clk) begin
    if (enq) begin
      pc_mem[wp]    <= if_pc;
      instr_mem[wp] <= if_instr;
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Testbench for if_id_queue: constant vector table, directed corner cases,
// and randomized traffic against a queue-based reference model.
module tb_if_id_queue;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam logic [31:0] K = 32'hA5A5_0000;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          if_valid;
  logic [31:0]   if_pc;
  logic [31:0]   if_instr;
  logic          if_freeze;
  logic          id_stall;
  logic          id_valid;
  logic [31:0]   id_pc;
  logic [31:0]   id_instr;
  logic [CW-1:0] count;

  if_id_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
    .if_freeze(if_freeze), .id_stall(id_stall),
    .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr),
    .count(count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int consumed = 0;
  logic [63:0] q[$];

  typedef struct {
    logic        fl;
    logic        v;
    logic [31:0] pc;
    logic        st;
    logic        ev;
    logic [31:0] epc;
    int          ecnt;
    logic        efz;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(logic fl, logic v, logic [31:0] pc, logic st,
                              logic ev, logic [31:0] epc, int ecnt, logic efz);
    vec_t r;
    r.fl = fl; r.v = v; r.pc = pc; r.st = st;
    r.ev = ev; r.epc = epc; r.ecnt = ecnt; r.efz = efz;
    return r;
  endfunction

  task automatic drive(input logic fl, input logic v, input logic [31:0] pc, input logic st);
    flush = fl; if_valid = v; if_pc = pc; if_instr = pc ^ K; id_stall = st;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    q.delete();
    #1;
  endtask

  // One cycle against the reference model: check outputs mid-cycle, then advance.
  task automatic step(input logic fl, input logic v, input logic [31:0] pc, input logic st);
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic        was_full;
    logic        took;
    drive(fl, v, pc, st);
    #1;
    e_valid = (q.size() != 0);
    e_pc    = e_valid ? q[0][63:32] : 32'h0;
    e_instr = e_valid ? q[0][31:0]  : 32'h0;
`ifdef IF_ID_QUEUE_BYPASS_EN
    if (q.size() == 0 && v && !fl) begin
      e_valid = 1'b1; e_pc = pc; e_instr = pc ^ K;
    end
`endif
    chk("id_valid",  32'(id_valid),  32'(e_valid));
    chk("id_pc",     id_pc,          e_pc);
    chk("id_instr",  id_instr,       e_instr);
    chk("if_freeze", 32'(if_freeze), 32'(q.size() == DEPTH));
    chk("count",     32'(count),     32'(q.size()));
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      was_full = (q.size() == DEPTH);
      took = 1'b0;
`ifdef IF_ID_QUEUE_BYPASS_EN
      if (q.size() == 0 && v && !st) begin
        took = 1'b1;
        consumed++;
      end
`endif
      if (!took) begin
        if (q.size() != 0 && !st) begin
          void'(q.pop_front());
          consumed++;
        end
        if (v && !was_full) q.push_back({pc, pc ^ K});
      end
    end
    #1;
  endtask

  initial begin
    int          acc;
    int          cyc;
    logic [31:0] npc;
    logic        v;
    logic        st;
    logic        will_acc;

    rst = 1'b1;
    drive(0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_id_valid",  32'(id_valid),  0);
    chk("rst_id_pc",     id_pc,          0);
    chk("rst_id_instr",  id_instr,       0);
    chk("rst_if_freeze", 32'(if_freeze), 0);
    chk("rst_count",     32'(count),     0);
    #1 rst = 1'b0;
    #1;

    // Fill to full, drain, flush with branch target, simultaneous enq/deq at DEPTH-1.
    tbl.push_back(mk(0, 1, 32'h000, 1, 1, 32'h000, 1, 0));
    tbl.push_back(mk(0, 1, 32'h004, 1, 1, 32'h000, 2, 0));
    tbl.push_back(mk(0, 1, 32'h008, 1, 1, 32'h000, 3, 0));
    tbl.push_back(mk(0, 1, 32'h00C, 1, 1, 32'h000, 4, 1));
    tbl.push_back(mk(0, 1, 32'h010, 1, 1, 32'h000, 4, 1));
    tbl.push_back(mk(0, 1, 32'h010, 0, 1, 32'h004, 3, 0));
    tbl.push_back(mk(0, 1, 32'h010, 0, 1, 32'h008, 3, 0));
    tbl.push_back(mk(0, 1, 32'h014, 0, 1, 32'h00C, 3, 0));
    tbl.push_back(mk(0, 0, 32'h000, 0, 1, 32'h010, 2, 0));
    tbl.push_back(mk(0, 0, 32'h000, 0, 1, 32'h014, 1, 0));
    tbl.push_back(mk(0, 0, 32'h000, 0, 0, 32'h000, 0, 0));
    tbl.push_back(mk(0, 1, 32'h100, 1, 1, 32'h100, 1, 0));
    tbl.push_back(mk(0, 1, 32'h104, 1, 1, 32'h100, 2, 0));
    tbl.push_back(mk(0, 1, 32'h108, 1, 1, 32'h100, 3, 0));
    tbl.push_back(mk(1, 1, 32'h00C, 0, 0, 32'h000, 0, 0));
    tbl.push_back(mk(0, 1, 32'h040, 1, 1, 32'h040, 1, 0));
    tbl.push_back(mk(0, 1, 32'h044, 0, 1, 32'h044, 1, 0));
    tbl.push_back(mk(0, 0, 32'h000, 0, 0, 32'h000, 0, 0));
    tbl.push_back(mk(0, 1, 32'h200, 1, 1, 32'h200, 1, 0));
    tbl.push_back(mk(0, 1, 32'h204, 1, 1, 32'h200, 2, 0));
    tbl.push_back(mk(0, 1, 32'h208, 1, 1, 32'h200, 3, 0));
    tbl.push_back(mk(0, 1, 32'h20C, 0, 1, 32'h204, 3, 0));
    tbl.push_back(mk(0, 0, 32'h000, 0, 1, 32'h208, 2, 0));
    tbl.push_back(mk(0, 0, 32'h000, 0, 1, 32'h20C, 1, 0));
    tbl.push_back(mk(0, 0, 32'h000, 0, 0, 32'h000, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].fl, tbl[i].v, tbl[i].pc, tbl[i].st);
      @(posedge clk);
      #1;
      flush = 1'b0; if_valid = 1'b0;
      #1;
      chk($sformatf("tbl%0d_valid", i),  32'(id_valid),  32'(tbl[i].ev));
      chk($sformatf("tbl%0d_pc", i),     id_pc,          tbl[i].epc);
      chk($sformatf("tbl%0d_instr", i),  id_instr,       tbl[i].ev ? (tbl[i].epc ^ K) : 32'h0);
      chk($sformatf("tbl%0d_count", i),  32'(count),     32'(tbl[i].ecnt));
      chk($sformatf("tbl%0d_freeze", i), 32'(if_freeze), 32'(tbl[i].efz));
    end

    // Asynchronous reset mid-stream with two words queued.
    drive(0, 1, 32'h300, 1);
    @(posedge clk); #1;
    drive(0, 1, 32'h304, 1);
    @(posedge clk); #1;
    if_valid = 1'b0;
    #1;
    chk("pre_rst_count", 32'(count), 2);
    rst = 1'b1;
    #1;
    chk("async_rst_valid",  32'(id_valid),  0);
    chk("async_rst_count",  32'(count),     0);
    chk("async_rst_freeze", 32'(if_freeze), 0);
    chk("async_rst_pc",     id_pc,          0);
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
    #1;

    // Streaming with no stalls.
    for (int i = 0; i < 10; i++) step(0, 1, 32'(i * 4), 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    // Wrap-around: 3*DEPTH words with id_stall toggling; fetch holds its PC while frozen.
    do_reset();
    consumed = 0;
    acc = 0;
    cyc = 0;
    npc = 32'h1000;
    while ((acc < 3 * DEPTH || q.size() != 0) && cyc < 200) begin
      v  = (acc < 3 * DEPTH);
      st = cyc[0];
      will_acc = v && (q.size() != DEPTH);
      step(0, v, npc, st);
      if (will_acc) begin
        npc = npc + 4;
        acc++;
      end
      cyc++;
    end
    chk("wrap_no_timeout", 32'(cyc < 200), 1);
    chk("wrap_consumed",   32'(consumed),  32'(3 * DEPTH));

`ifdef IF_ID_QUEUE_BYPASS_EN
    // Zero-latency bypass: consumed directly, then held under stall.
    do_reset();
    drive(0, 1, 32'h8, 0);
    #1;
    chk("byp_valid", 32'(id_valid), 1);
    chk("byp_pc",    id_pc,         32'h8);
    @(posedge clk); #1;
    if_valid = 1'b0;
    #1;
    chk("byp_count0", 32'(count),    0);
    chk("byp_empty",  32'(id_valid), 0);
    drive(0, 1, 32'h8, 1);
    #1;
    chk("byp_st_pc", id_pc, 32'h8);
    @(posedge clk); #1;
    if_valid = 1'b0;
    #1;
    chk("byp_st_count", 32'(count),    1);
    chk("byp_st_hold",  id_pc,         32'h8);
    chk("byp_st_valid", 32'(id_valid), 1);
`endif

    // Randomized traffic against the reference model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 4);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
